// File: rtl/miner_host_pkg.sv
// miner_host_pkg
// Shared constants and types for the miner host bridge and miner_top.
//   SYNC_RX / SYNC_TX  : frame sync bytes for the host->miner and miner->host directions
//   HDR_BYTES/TGT_BYTES: job payload sizes in bytes; HDR_W/TGT_W are the matching bit widths
//   rx_state_t         : RX frame parser states
//   nonce_byte()       : picks nonce byte 0..3, most significant first
// Optional feature macro: MINER_HOST_CHECKSUM_EN (adds the checksum state to the RX frame).
package miner_host_pkg;

    localparam int HDR_BYTES   = 76;
    localparam int TGT_BYTES   = 32;
    localparam int HDR_W       = HDR_BYTES * 8;
    localparam int TGT_W       = TGT_BYTES * 8;
    localparam int NONCE_BYTES = 4;

    localparam logic [7:0] SYNC_RX = 8'hA5;
    localparam logic [7:0] SYNC_TX = 8'h5A;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_HDR,
        RX_TGT,
        RX_CHK,
        RX_COMMIT
    } rx_state_t;

    function automatic logic [7:0] nonce_byte(input logic [31:0] n, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = n[31:24];
            2'd1:    b = n[23:16];
            2'd2:    b = n[15:8];
            default: b = n[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/miner_host_bridge_nonce_tx_serializer.sv
// nonce_tx_serializer
// Queues golden nonces (2 entries) and sends each one to the host as
// SYNC_TX followed by the nonce bytes, most significant first.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   nonce, nonce_found  : nonce from the miner and its one-cycle qualifier
//   tx_data, tx_valid   : registered byte stream to the host
//   tx_ready            : host accepts the current byte
//   nonce_dropped       : one-cycle pulse when a nonce arrives with the queue full
module nonce_tx_serializer
    import miner_host_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] nonce,
    input  logic        nonce_found,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        nonce_dropped
);

    logic [31:0] q0, q1;        // q0 is the head, being sent while tx_valid=1
    logic [1:0]  q_cnt;
    logic [2:0]  byte_idx;      // 0 = sync byte on the wire, 1..4 = nonce bytes

    logic last_xfer, full, push_ok;

    assign last_xfer = tx_valid && tx_ready && (byte_idx == 3'(NONCE_BYTES));
    assign full      = (q_cnt == 2'd2);
    // The pop on the final byte frees a slot in the same cycle.
    assign push_ok   = nonce_found && (!full || last_xfer);

    always_ff @(posedge clk) begin
        if (rst) begin
            q0            <= '0;
            q1            <= '0;
            q_cnt         <= '0;
            byte_idx      <= '0;
            tx_data       <= '0;
            tx_valid      <= 1'b0;
            nonce_dropped <= 1'b0;
        end else begin
            nonce_dropped <= nonce_found && full && !last_xfer;

            if (last_xfer) begin
                q0 <= q1;
                if (push_ok) begin
                    if (q_cnt == 2'd2) q1 <= nonce;
                    else               q0 <= nonce;
                end
                q_cnt <= q_cnt - 2'd1 + {1'b0, push_ok};
            end else if (push_ok) begin
                if (q_cnt == 2'd0) q0 <= nonce;
                else               q1 <= nonce;
                q_cnt <= q_cnt + 2'd1;
            end

            if (!tx_valid) begin
                if (q_cnt != 2'd0) begin
                    tx_valid <= 1'b1;
                    tx_data  <= SYNC_TX;
                    byte_idx <= '0;
                end
            end else if (tx_ready) begin
                if (byte_idx == 3'(NONCE_BYTES)) begin
                    byte_idx <= '0;
                    // Second entry already waiting: start its sync byte with no gap.
                    if (q_cnt == 2'd2) begin
                        tx_data <= SYNC_TX;
                    end else begin
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                    end
                end else begin
                    byte_idx <= byte_idx + 3'd1;
                    tx_data  <= nonce_byte(q0, byte_idx[1:0]);
                end
            end
        end
    end

endmodule

// File: rtl/miner_host_bridge.sv
// miner_host_bridge
// Host-side job/result bridge for miner_top. Parses framed host bytes
// (SYNC_RX, 76 header bytes, 32 target bytes[, checksum]) into shadow
// registers and applies them atomically; returns golden nonces through
// nonce_tx_serializer.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   rx_data, rx_valid, rx_ready   : host byte input handshake
//   header, target, work_valid    : current job and its one-cycle update strobe
//   nonce, nonce_found            : golden nonce from the miner
//   tx_data, tx_valid, tx_ready   : result byte output handshake
//   nonce_dropped                 : nonce lost because the queue was full
//   frame_err                     : checksum mismatch pulse
// Macro MINER_HOST_CHECKSUM_EN: adds the RX_CHK state (XOR of the 108 payload
// bytes); without it frame_err is tied low.
//
// state     | meaning
// RX_IDLE   | hunting for SYNC_RX, other bytes dropped
// RX_HDR    | shifting 76 header bytes into shadow_hdr
// RX_TGT    | shifting 32 target bytes into shadow_tgt
// RX_CHK    | comparing the checksum byte (checksum build only)
// RX_COMMIT | rx_ready low, shadows copied out, work_valid pulsed
module miner_host_bridge
    import miner_host_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [HDR_W-1:0] header,
    output logic [TGT_W-1:0] target,
    output logic             work_valid,
    input  logic [31:0]      nonce,
    input  logic             nonce_found,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             nonce_dropped,
    output logic             frame_err
);

    rx_state_t        state;
    logic [6:0]       byte_cnt;
    logic [HDR_W-1:0] shadow_hdr;
    logic [TGT_W-1:0] shadow_tgt;
    logic             rx_xfer;

    assign rx_xfer = rx_valid && rx_ready;

`ifdef MINER_HOST_CHECKSUM_EN
    logic [7:0] csum;
    logic       frame_err_q;
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    // Bytes are shifted in at the LSB end, so after the last one the first
    // byte of each field sits in its most significant position.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            byte_cnt   <= '0;
            shadow_hdr <= '0;
            shadow_tgt <= '0;
            header     <= '0;
            target     <= '0;
            work_valid <= 1'b0;
            rx_ready   <= 1'b0;
`ifdef MINER_HOST_CHECKSUM_EN
            csum        <= '0;
            frame_err_q <= 1'b0;
`endif
        end else begin
            work_valid <= 1'b0;
            rx_ready   <= 1'b1;
`ifdef MINER_HOST_CHECKSUM_EN
            frame_err_q <= 1'b0;
`endif
            case (state)
                RX_IDLE: begin
                    if (rx_xfer && rx_data == SYNC_RX) begin
                        state    <= RX_HDR;
                        byte_cnt <= '0;
`ifdef MINER_HOST_CHECKSUM_EN
                        csum <= '0;
`endif
                    end
                end
                RX_HDR: begin
                    if (rx_xfer) begin
                        shadow_hdr <= {shadow_hdr[HDR_W-9:0], rx_data};
`ifdef MINER_HOST_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        if (byte_cnt == 7'(HDR_BYTES - 1)) begin
                            state    <= RX_TGT;
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 7'd1;
                        end
                    end
                end
                RX_TGT: begin
                    if (rx_xfer) begin
                        shadow_tgt <= {shadow_tgt[TGT_W-9:0], rx_data};
`ifdef MINER_HOST_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        if (byte_cnt == 7'(TGT_BYTES - 1)) begin
                            byte_cnt <= '0;
`ifdef MINER_HOST_CHECKSUM_EN
                            state <= RX_CHK;
`else
                            state    <= RX_COMMIT;
                            rx_ready <= 1'b0;
`endif
                        end else begin
                            byte_cnt <= byte_cnt + 7'd1;
                        end
                    end
                end
`ifdef MINER_HOST_CHECKSUM_EN
                RX_CHK: begin
                    if (rx_xfer) begin
                        if (rx_data == csum) begin
                            state    <= RX_COMMIT;
                            rx_ready <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= RX_IDLE;
                        end
                    end
                end
`endif
                RX_COMMIT: begin
                    header     <= shadow_hdr;
                    target     <= shadow_tgt;
                    work_valid <= 1'b1;
                    state      <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    nonce_tx_serializer u_tx (
        .clk           (clk),
        .rst           (rst),
        .nonce         (nonce),
        .nonce_found   (nonce_found),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .nonce_dropped (nonce_dropped)
    );

endmodule

// File: tb/tb_miner_host_bridge.sv
// tb_miner_host_bridge
// Directed bench for miner_host_bridge. A frame-level model (byte buffer,
// nonce queue of whole messages) predicts every output; a negedge process
// compares the DUT against it each cycle, and literal checks pin the model.
// Honours MINER_HOST_CHECKSUM_EN in the same way as the design.
module tb_miner_host_bridge;
    import miner_host_pkg::*;

`ifdef MINER_HOST_CHECKSUM_EN
    localparam int CHK_EN = 1;
`else
    localparam int CHK_EN = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [HDR_W-1:0] header;
    logic [TGT_W-1:0] target;
    logic             work_valid;
    logic [31:0]      nonce;
    logic             nonce_found;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             nonce_dropped;
    logic             frame_err;

    always #10 clk = ~clk;

    miner_host_bridge dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .header        (header),
        .target        (target),
        .work_valid    (work_valid),
        .nonce         (nonce),
        .nonce_found   (nonce_found),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .nonce_dropped (nonce_dropped),
        .frame_err     (frame_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkw(input string name, input logic [HDR_W-1:0] act, input logic [HDR_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    logic [HDR_W-1:0] m_header, sh_h;
    logic [TGT_W-1:0] m_target, sh_t;
    logic             m_wv, m_rr, m_fe, m_drop;
    logic [7:0]       fbuf [0:108];
    int               k;
    bit               commit_pend;
    logic [31:0]      mq [$];
    int               sent;
    bit               hs_flag, hs_unexp, hold_chk, armed;
    logic [7:0]       hs_act, hs_exp, held;
    logic [7:0]       tx_log [$];
    int               tx_cyc [$];
    int               cyc = 0;
    int               wv_cnt = 0, fe_cnt = 0, drop_cnt = 0;

    always @(posedge clk) begin
        logic [7:0]  x;
        logic [31:0] head;
        cyc++;
        hs_flag  = 1'b0;
        hs_unexp = 1'b0;
        if (rst) begin
            m_header = '0; m_target = '0;
            m_wv = 1'b0; m_rr = 1'b0; m_fe = 1'b0; m_drop = 1'b0;
            k = -1; commit_pend = 1'b0;
            mq.delete(); sent = 0; hold_chk = 1'b0;
            armed = 1'b1;
        end else begin
            m_wv = 1'b0; m_fe = 1'b0; m_drop = 1'b0;
            if (commit_pend) begin
                m_header = sh_h; m_target = sh_t; m_wv = 1'b1; commit_pend = 1'b0;
            end else if (rx_valid && m_rr) begin
                if (k < 0) begin
                    if (rx_data == SYNC_RX) k = 0;
                end else begin
                    fbuf[k] = rx_data;
                    k++;
                    if (k == HDR_BYTES + TGT_BYTES + CHK_EN) begin
                        for (int i = 0; i < HDR_BYTES; i++) sh_h[HDR_W-1-8*i -: 8] = fbuf[i];
                        for (int i = 0; i < TGT_BYTES; i++) sh_t[TGT_W-1-8*i -: 8] = fbuf[HDR_BYTES+i];
                        x = '0;
                        for (int i = 0; i < HDR_BYTES + TGT_BYTES; i++) x ^= fbuf[i];
                        if (CHK_EN == 0 || x == fbuf[108]) commit_pend = 1'b1;
                        else m_fe = 1'b1;
                        k = -1;
                    end
                end
            end
            m_rr = !commit_pend;

            if (tx_valid && tx_ready) begin
                if (mq.size() == 0) begin
                    hs_unexp = 1'b1;
                end else begin
                    head    = mq[0];
                    hs_exp  = (sent == 0) ? SYNC_TX : head[31-8*(sent-1) -: 8];
                    hs_act  = tx_data;
                    hs_flag = 1'b1;
                    tx_log.push_back(tx_data);
                    tx_cyc.push_back(cyc);
                    sent++;
                    if (sent == 5) begin
                        void'(mq.pop_front());
                        sent = 0;
                    end
                end
            end
            hold_chk = tx_valid && !tx_ready;
            held     = tx_data;
            if (nonce_found) begin
                if (mq.size() < 2) mq.push_back(nonce);
                else m_drop = 1'b1;
            end
        end
    end

    // ---------------- compare ----------------
    always @(negedge clk) begin
        if (armed) begin
            checkw("header", header, m_header);
            checkw("target", {{(HDR_W-TGT_W){1'b0}}, target}, {{(HDR_W-TGT_W){1'b0}}, m_target});
            check("work_valid", 32'(work_valid), 32'(m_wv));
            check("rx_ready", 32'(rx_ready), 32'(m_rr));
            check("frame_err", 32'(frame_err), 32'(m_fe));
            check("nonce_dropped", 32'(nonce_dropped), 32'(m_drop));
            if (hs_flag) check("tx_byte", 32'(hs_act), 32'(hs_exp));
            if (hs_unexp) begin
                checks++; failures++;
                $display("FAIL tx_unexpected actual=%0h required=no_transfer", hs_act);
            end
            if (hold_chk) begin
                check("tx_hold_valid", 32'(tx_valid), 32'd1);
                check("tx_hold_data", 32'(tx_data), 32'(held));
            end
            if (tx_valid && mq.size() == 0) begin
                checks++; failures++;
                $display("FAIL tx_valid_idle actual=1 required=0");
            end
            wv_cnt   += int'(work_valid);
            fe_cnt   += int'(frame_err);
            drop_cnt += int'(nonce_dropped);
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] fr [0:109];
    int         flen;

    task automatic build_frame(input int kind, input bit corrupt);
        logic [7:0] x;
        fr[0] = SYNC_RX;
        for (int i = 0; i < HDR_BYTES; i++) fr[1+i] = (kind == 0) ? 8'(i) : 8'(i*7 + 3);
        if (kind == 1) begin
            fr[2] = 8'hA5;
            fr[3] = 8'hA5;
        end
        for (int i = 0; i < TGT_BYTES; i++)
            fr[77+i] = (kind == 0) ? ((i < 4) ? 8'hFF : 8'h00) : 8'(255 - i);
        x = '0;
        for (int i = 1; i < 109; i++) x ^= fr[i];
        fr[109] = corrupt ? ~x : x;
        flen = 109 + CHK_EN;
    endtask

    // Called at a negedge; returns at the negedge after the transferring edge.
    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            checks++; failures++;
            $display("FAIL rx_ready_timeout actual=0 required=1");
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) send_byte(fr[i]);
        rx_valid = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] v);
        nonce       = v;
        nonce_found = 1'b1;
        @(negedge clk);
        nonce_found = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        int w;
        w = 0;
        while (tx_log.size() < n && w < budget) begin
            @(negedge clk);
            w++;
        end
        if (tx_log.size() < n) begin
            checks++; failures++;
            $display("FAIL tx_timeout actual=%0d required=%0d", tx_log.size(), n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_a [0:9];
        int d0, wv0;
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
        nonce = '0; nonce_found = 1'b0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkw("rst_header", header, '0);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_work_valid", 32'(work_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rx_ready_after_rst", 32'(rx_ready), 32'd1);

        // valid frame, commit two edges after the last byte
        build_frame(0, 1'b0);
        send_frame(flen);
        check("wv_edge_n", 32'(work_valid), 32'd0);
        check("rx_ready_commit", 32'(rx_ready), 32'd0);
        @(negedge clk);
        check("wv_edge_n1", 32'(work_valid), 32'd1);
        repeat (3) @(negedge clk);
        check("hdr_msb", 32'(header[607:600]), 32'h00);
        check("hdr_lsb", 32'(header[7:0]), 32'h4B);
        checkw("tgt_val", {352'h0, target}, {352'h0, 32'hFFFFFFFF, 224'h0});
        check("wv_count1", 32'(wv_cnt), 32'd1);

        // junk before sync
        send_byte(8'h00); send_byte(8'h12); send_byte(8'hFF);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("wv_junk", 32'(wv_cnt), 32'd1);
        send_frame(flen);
        repeat (3) @(negedge clk);
        check("hdr_lsb2", 32'(header[7:0]), 32'h4B);
        check("wv_count2", 32'(wv_cnt), 32'd2);

        // 0xA5 inside the payload is data
        build_frame(1, 1'b0);
        send_frame(flen);
        repeat (3) @(negedge clk);
        check("hdr_a5_b0", 32'(header[607:600]), 32'h03);
        check("hdr_a5_b1", 32'(header[599:592]), 32'hA5);
        check("tgt_k1_lsb", 32'(target[7:0]), 32'hE0);
        check("wv_count3", 32'(wv_cnt), 32'd3);

`ifdef MINER_HOST_CHECKSUM_EN
        build_frame(0, 1'b1);
        send_frame(flen);
        repeat (3) @(negedge clk);
        check("fe_count", 32'(fe_cnt), 32'd1);
        check("hdr_kept", 32'(header[599:592]), 32'hA5);
        check("wv_count_bad", 32'(wv_cnt), 32'd3);
`endif

        // single nonce, latency and toggling tx_ready
        tx_log.delete(); tx_cyc.delete();
        strobe(32'hDEADBEEF);
        check("tx_lat_n", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check("tx_lat_n1_valid", 32'(tx_valid), 32'd1);
        check("tx_lat_n1_data", 32'(tx_data), 32'h5A);
        for (int w = 0; w < 40 && tx_log.size() < 5; w++) begin
            tx_ready = ~tx_ready;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        wait_log(5, 1);
        exp_a[0] = 8'h5A; exp_a[1] = 8'hDE; exp_a[2] = 8'hAD; exp_a[3] = 8'hBE; exp_a[4] = 8'hEF;
        for (int i = 0; i < 5 && i < tx_log.size(); i++) check("deadbeef_seq", 32'(tx_log[i]), 32'(exp_a[i]));

        // three strobes with tx_ready low: third drops
        repeat (2) @(negedge clk);
        tx_log.delete(); tx_cyc.delete();
        d0 = drop_cnt;
        strobe(32'd1); strobe(32'd2); strobe(32'd3);
        repeat (2) @(negedge clk);
        check("drop_count", 32'(drop_cnt - d0), 32'd1);
        tx_ready = 1'b1;
        wait_log(10, 40);
        exp_a[0] = 8'h5A; exp_a[1] = 8'h00; exp_a[2] = 8'h00; exp_a[3] = 8'h00; exp_a[4] = 8'h01;
        exp_a[5] = 8'h5A; exp_a[6] = 8'h00; exp_a[7] = 8'h00; exp_a[8] = 8'h00; exp_a[9] = 8'h02;
        for (int i = 0; i < 10 && i < tx_log.size(); i++) check("two_msg_seq", 32'(tx_log[i]), 32'(exp_a[i]));
        if (tx_cyc.size() >= 6) check("back_to_back", 32'(tx_cyc[5] - tx_cyc[4]), 32'd1);
        else check("back_to_back_len", 32'(tx_cyc.size()), 32'd6);

        // queue full under continuous strobes: push+pop while full
        repeat (3) @(negedge clk);
        tx_ready = 1'b0;
        strobe(32'hA0000000); strobe(32'hA0000001);
        tx_ready = 1'b1;
        for (int i = 0; i < 14; i++) strobe(32'hB0000000 + 32'(i));
        for (int w = 0; w < 100 && (mq.size() != 0 || tx_valid); w++) @(negedge clk);
        check("drain_empty", 32'(mq.size()), 32'd0);

        // reset mid-frame and mid-message, then a fresh frame
        tx_ready = 1'b0;
        strobe(32'hCAFEF00D);
        build_frame(0, 1'b0);
        send_frame(41);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkw("midrst_header", header, '0);
        check("midrst_target", 32'(target[255:224]), 32'd0);
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        wv0 = wv_cnt;
        send_frame(flen);
        repeat (3) @(negedge clk);
        check("fresh_hdr_lsb", 32'(header[7:0]), 32'h4B);
        check("fresh_tgt_msw", 32'(target[255:224]), 32'hFFFFFFFF);
        check("fresh_wv", 32'(wv_cnt - wv0), 32'd1);
        tx_log.delete(); tx_cyc.delete();
        tx_ready = 1'b1;
        strobe(32'h12345678);
        wait_log(5, 20);
        exp_a[0] = 8'h5A; exp_a[1] = 8'h12; exp_a[2] = 8'h34; exp_a[3] = 8'h56; exp_a[4] = 8'h78;
        for (int i = 0; i < 5 && i < tx_log.size(); i++) check("post_rst_seq", 32'(tx_log[i]), 32'(exp_a[i]));
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/miner_host_bridge.md
# miner_host_bridge

Host-side work/result bridge for `miner_top`. It deserialises a framed byte stream from the host link into the 608-bit block header and 256-bit target that feed the miner, and presents each new job atomically with a one-cycle strobe. In the return direction it serialises every golden nonce reported by the miner back to the host as a short framed byte message. It sits between the byte-level host transport (UART/FIFO) and `miner_top`.

## Interface
- `HDR_BYTES`, 76: header payload bytes (608 bits).
- `TGT_BYTES`, 32: target payload bytes (256 bits).
- `clk`  in  1  system clock (50 MHz)
- `rst`  in  1  synchronous, active-high reset
- `rx_data`  in  8  host byte in
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  bridge accepts byte
- `header`  out  608  current job header to `miner_top`
- `target`  out  256  current job target to `miner_top`
- `work_valid`  out  1  one-cycle strobe: new header/target applied
- `nonce`  in  32  golden nonce from miner
- `nonce_found`  in  1  one-cycle strobe qualifying `nonce`
- `tx_data`  out  8  result byte to host
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  host accepts byte
- `nonce_dropped`  out  1  one-cycle pulse: nonce lost (queue full)
- `frame_err`  out  1  one-cycle pulse: checksum mismatch (only with `MINER_HOST_CHECKSUM_EN`)

## Operation
- A byte transfers on a rising edge with `rx_valid & rx_ready`. Likewise, a TX byte transfers on a rising edge with `tx_valid & tx_ready`.
- RX FSM states: IDLE, HDR, TGT, CHK, COMMIT.
  - IDLE: consume bytes; on 0xA5, go to HDR. Discard any other byte silently.
  - HDR: 76 bytes, MSB first. The first byte lands in `shadow_hdr[607:600]`. Go to TGT after the 76th byte.
  - TGT: 32 bytes, MSB first. The first byte lands in `shadow_tgt[255:248]`. Go to CHK if the macro is defined, else COMMIT.
  - CHK: one byte, compared with the XOR of all 108 payload bytes. On match, go to COMMIT. On mismatch, pulse `frame_err` and go to IDLE.
  - COMMIT: `rx_ready=0`. Copy the shadows to `header`/`target`, assert `work_valid`, go to IDLE.
- `header`/`target` change only in COMMIT. The miner never sees a partial job.
- The byte counter is 7-bit and counts 0..75 in HDR and 0..31 in TGT; it clears on every state change.
- TX path uses a 2-entry nonce queue.
  - `nonce_found` pushes `nonce`.
  - If `nonce_found` arrives with the queue full, the nonce is not stored and `nonce_dropped` pulses.
  - A simultaneous push and pop while full is accepted, with no drop.
- Serialiser message: 0x5A, then nonce[31:24], [23:16], [15:8], [7:0]. `tx_valid` holds and `tx_data` stays stable until `tx_ready`. The entry pops after the last byte is accepted.

## Timing
- Reset values:
  - `header=0`, `target=0`, `work_valid=0`, `rx_ready=0`.
  - `tx_valid=0`, `tx_data=0`, `nonce_dropped=0`, `frame_err=0`.
  - RX FSM in IDLE, queue empty.
- `rx_ready=1` from the first cycle after reset is deasserted, except in COMMIT.
- The last payload/checksum byte accepted at edge N moves the FSM to COMMIT. At edge N+1, `header`/`target` update and `work_valid=1` for exactly that one cycle.
- Nonce latency: a `nonce_found` sampled at edge N (queue empty, serialiser idle) produces `tx_valid=1` with `tx_data=0x5A` after edge N+1.
- Back-to-back messages need no idle cycle between the last byte and the next 0x5A.
- Reset mid-frame discards the partial frame. Reset mid-TX aborts the message and empties the queue.
- A 0xA5 inside the payload is data, not a resync.

## Configuration
- `MINER_HOST_CHECKSUM_EN` defined: the CHK state exists, and a frame is 110 bytes including sync. `frame_err` is live.
- Not defined: no CHK state, and a frame is 109 bytes. `frame_err` is tied 0.

## Structure
- `miner_host_pkg` holds:
  - `SYNC_RX=8'hA5`, `SYNC_TX=8'h5A`, `HDR_BYTES`, `TGT_BYTES`;
  - the RX state enum;
  - the header/target width constants (608/256) shared with `miner_top`.
- Sub-module `nonce_tx_serializer` contains the 2-entry queue, the byte index and the tx handshake. The top level holds the RX FSM and shadows.

## Test plan
- Valid frame: 0xA5, header bytes 0x00..0x4B, target 0xFF×4 then 0x00×28 (plus correct checksum if enabled). Required: `header[607:600]=0x00`, `header[7:0]=0x4B`, `target=256'hFFFFFFFF_00…0`, and one `work_valid` pulse two edges after the last byte.
- Junk before sync: 0x00, 0x12, 0xFF, then a valid frame. Required: junk ignored, job applied identically, no `work_valid` on the junk.
- Nonce 0xDEADBEEF with `tx_ready` toggling every other cycle. Required: `tx_data` sequence 5A, DE, AD, BE, EF, with each byte held stable while `tx_ready=0`.
- Three `nonce_found` strobes on consecutive cycles (1, 2, 3) with `tx_ready=0`. Required: the third raises `nonce_dropped`; after release, messages carry 0x00000001 then 0x00000002.
- With the macro defined: a frame with a corrupted checksum. Required: a `frame_err` pulse, `header`/`target` unchanged, no `work_valid`.
- `rst` after 40 header bytes, then a fresh valid frame. Required: outputs zeroed, and the fresh frame is applied correctly.
